// File: rtl/lut_arbiter.sv
// lut_arbiter: an 8-entry lookup table for immediates and constants, shared by two
// read requesters under round-robin arbitration. Each lookup returns a registered
// result one cycle after it is accepted.
//
// Optional feature macro: LUT_WRITE_EN
//   defined   - the wr_en/wr_idx/wr_data ports exist and the table is a writable
//               register array that resets to the default contents.
//   undefined - the table is a constant combinational ROM holding the defaults.
//
// Handshake (valid/ready):
//   - A request transfers on a rising edge where reqN_valid && reqN_ready.
//   - The requester holds reqN_valid and reqN_idx stable until it sees reqN_ready.
//   - reqN_ready is combinational from the valid inputs, wr_en and last_grant.
//     It is never high while reqN_valid is low.
//   - rspN_valid is a single-cycle pulse in the cycle after acceptance.
//     Responses cannot be back-pressured.
//   - rspN_data holds its value until the next response on that port.
module lut_arbiter #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_idx,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_data,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_idx,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_data
`ifdef LUT_WRITE_EN
    ,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [DW-1:0] wr_data
`endif
);

    localparam int DEPTH = 2 ** AW;

    // Default table contents. Negative values are sign-extended or truncated to DW.
    // Any entry beyond index 7 defaults to zero.
    function automatic logic [DW-1:0] lut_default(input int i);
        int v;
        case (i)
            0:       v = 100;
            1:       v = 10;
            2:       v = 5;
            3:       v = 1;
            4:       v = 0;
            5:       v = -1;
            6:       v = -30;
            7:       v = -5;
            default: v = 0;
        endcase
        return DW'(v);
    endfunction

    // last_grant: 0 means port 0 was granted most recently, 1 means port 1.
    logic          last_grant;
    logic          wr_block;
    logic          grant0;
    logic          grant1;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;

`ifdef LUT_WRITE_EN
    logic [DW-1:0] lut_q [DEPTH];

    assign wr_block = wr_en;
    assign rd0      = lut_q[req0_idx];
    assign rd1      = lut_q[req1_idx];

    // Table storage: reset restores the defaults.
    // A write lands only in a cycle where no read is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut_q[i] <= lut_default(i);
            end
        end else if (wr_en) begin
            lut_q[wr_idx] <= wr_data;
        end
    end
`else
    assign wr_block = 1'b0;
    assign rd0      = lut_default(int'(req0_idx));
    assign rd1      = lut_default(int'(req1_idx));
`endif

    // Round-robin grant. A write blocks both ports.
    // Under contention, the port that was not granted last wins.
    always_comb begin
        grant0 = req0_valid && !wr_block && (!req1_valid || last_grant);
        grant1 = req1_valid && !wr_block && (!req0_valid || !last_grant);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Record the winner. last_grant moves only when a read is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0 || grant1) begin
            last_grant <= grant1;
        end
    end

    // Port 0 response register: pulse valid, and capture data only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
        end else begin
            rsp0_valid <= grant0;
            if (grant0) begin
                rsp0_data <= rd0;
            end
        end
    end

    // Port 1 response register: pulse valid, and capture data only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end else begin
            rsp1_valid <= grant1;
            if (grant1) begin
                rsp1_data <= rd1;
            end
        end
    end

endmodule

// File: tb/tb_lut_arbiter.sv
// tb_lut_arbiter: self-checking bench for lut_arbiter.
// A reference model predicts grants and table contents.
// Expected responses are queued on acceptance and compared when the DUT responds.
// Define LUT_WRITE_EN to exercise the write port.
module tb_lut_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [2:0] req0_idx;
    logic       req0_ready;
    logic       rsp0_valid;
    logic [7:0] rsp0_data;
    logic       req1_valid;
    logic [2:0] req1_idx;
    logic       req1_ready;
    logic       rsp1_valid;
    logic [7:0] rsp1_data;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;

    lut_arbiter #(.DW(8), .AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_idx   (req0_idx),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_idx   (req1_idx),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data)
`ifdef LUT_WRITE_EN
        ,
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data)
`endif
    );

    // Clock and reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state.
    logic [7:0] def_tab [8];
    logic [7:0] m_tab   [8];
    logic       m_last;
    logic       m_g0;
    logic       m_g1;
    logic [7:0] m_d0;
    logic [7:0] m_d1;

    // Scoreboard queues, one per port.
    logic [7:0] exp0_q [$];
    logic [7:0] exp1_q [$];

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_tab[i] = def_tab[i];
        m_last = 1'b1;
        m_d0 = 8'h00;
        m_d1 = 8'h00;
        exp0_q.delete();
        exp1_q.delete();
    endtask

    // Assert reset asynchronously, check that the outputs clear at once, then release.
    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req0_idx   = 3'd0;
        req1_valid = 1'b0;
        req1_idx   = 3'd0;
        wr_en      = 1'b0;
        wr_idx     = 3'd0;
        wr_data    = 8'h00;
        #1;
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_rsp0_data", rsp0_data, 8'h00);
        check("rst_rsp1_data", rsp1_data, 8'h00);
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Compare DUT responses against the scoreboard just after the edge.
    task automatic check_rsp();
        logic [7:0] d;
        if (exp0_q.size() > 0) begin
            d = exp0_q.pop_front();
            check("rsp0_valid", rsp0_valid, 1'b1);
            check("rsp0_data", rsp0_data, d);
            m_d0 = d;
        end else begin
            check("rsp0_idle", rsp0_valid, 1'b0);
            check("rsp0_hold", rsp0_data, m_d0);
        end
        if (exp1_q.size() > 0) begin
            d = exp1_q.pop_front();
            check("rsp1_valid", rsp1_valid, 1'b1);
            check("rsp1_data", rsp1_data, d);
            m_d1 = d;
        end else begin
            check("rsp1_idle", rsp1_valid, 1'b0);
            check("rsp1_hold", rsp1_data, m_d1);
        end
    endtask

    // Driver task for one cycle: apply the inputs, check ready against the model,
    // queue the expected responses, advance one clock, then check the responses.
    task automatic drive(input logic v0, input logic [2:0] i0,
                         input logic v1, input logic [2:0] i1,
                         input logic we, input logic [2:0] wi, input logic [7:0] wd);
        req0_valid = v0;
        req0_idx   = i0;
        req1_valid = v1;
        req1_idx   = i1;
        wr_en      = we;
        wr_idx     = wi;
        wr_data    = wd;
        #1;
        m_g0 = v0 && !wr_en && (!v1 || m_last);
        m_g1 = v1 && !wr_en && (!v0 || !m_last);
        check("req0_ready", req0_ready, m_g0);
        check("req1_ready", req1_ready, m_g1);
        if (m_g0) exp0_q.push_back(m_tab[i0]);
        if (m_g1) exp1_q.push_back(m_tab[i1]);
        if (m_g0 || m_g1) m_last = m_g1;
        if (wr_en) m_tab[wr_idx] = wr_data;
        @(posedge clk);
        #1;
        check_rsp();
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    endtask

    logic       r0v, r1v, rwe;
    logic [2:0] r0i, r1i, rwi;
    logic [7:0] rwd;

    initial begin
        def_tab = '{8'd100, 8'd10, 8'd5, 8'd1, 8'd0, 8'hFF, 8'hE2, 8'hFB};
        n_checks = 0;
        n_pass   = 0;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        do_reset();

        // Single lookup on port 0.
        drive(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
        check("single_rsp0_is_5", rsp0_data, 8'd5);
        idle();

        // Continuous contention after reset: port 0 must win first, then the ports alternate.
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("contend_first_p0", req0_ready, 1'b1);
        for (int k = 0; k < 6; k++) drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 8'h00);
        idle();

        // Only port 1 valid while last_grant is 1: it must be granted with no idle bubble.
        do_reset();
        drive(1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 8'h00);
        check("p1_alone_rsp", rsp1_data, 8'd0);

        // Back-to-back sweep of every index on port 1.
        for (int k = 0; k < 8; k++) drive(1'b0, 3'd0, 1'b1, 3'(k), 1'b0, 3'd0, 8'h00);
        check("sweep_last_fb", rsp1_data, 8'hFB);
        idle();

`ifdef LUT_WRITE_EN
        // A write blocks a read in the same cycle; the read accepted next sees the new value.
        drive(1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3, 8'h7A);
        drive(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
        check("wr_read_7a", rsp0_data, 8'h7A);
        // Write index 5, then read it back.
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 8'h11);
        drive(1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
        check("wr_read_11", rsp0_data, 8'h11);
`endif
        // Reset while a response is in flight; afterwards, index 5 reads its default.
        drive(1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
        do_reset();
        drive(1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
        check("post_rst_idx5_ff", rsp0_data, 8'hFF);
        idle();

        // Random traffic. Each requester keeps its request stable until it is accepted.
        r0v = 1'b0; r0i = 3'd0; r1v = 1'b0; r1i = 3'd0;
        for (int k = 0; k < 300; k++) begin
            rwe = 1'b0;
            rwi = 3'($urandom_range(0, 7));
            rwd = 8'($urandom_range(0, 255));
`ifdef LUT_WRITE_EN
            rwe = ($urandom_range(0, 7) == 0);
`endif
            drive(r0v, r0i, r1v, r1i, rwe, rwi, rwd);
            if (!r0v || m_g0) begin
                r0v = 1'($urandom_range(0, 1));
                r0i = 3'($urandom_range(0, 7));
            end
            if (!r1v || m_g1) begin
                r1v = 1'($urandom_range(0, 1));
                r1i = 3'($urandom_range(0, 7));
            end
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
